dmem_responder: RTL and testbench

- Data-memory slave at the responder end of the CPU load/store port.
- Accepts word-addressed requests carrying a 4-bit byte-write enable over a valid/ready handshake, then inserts a programmable number of wait states.
- Returns read data and error status over a second valid/ready handshake.
- Replaces the zero-latency combinational dmem so the core can be exercised against a multi-cycle memory.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait states, and a
// registered response channel. One request in flight; the array is written at the commit edge.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          NoWait   = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WaitLoad = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [3:0]  r_we, w_we_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] w_cur_addr;
  logic [3:0]  w_cur_we;
  logic [31:0] w_cur_wdata;
  logic        w_commit;
  logic        w_in_range;
  logic        w_we_ok;
  logic        w_legal;
  logic [AW-1:0] w_idx;
  logic [31:0] w_merged;
  logic        w_unused_addr;

  // With no wait states the commit happens on the acceptance edge, so use the live request.
  assign w_cur_addr  = (r_state == StIdle) ? req_addr  : r_addr;
  assign w_cur_we    = (r_state == StIdle) ? req_we    : r_we;
  assign w_cur_wdata = (r_state == StIdle) ? req_wdata : r_wdata;

  assign w_commit = (NoWait && (r_state == StIdle) && req_valid) ||
                    ((r_state == StWait) && (r_cnt == 4'd0));

  // Full 30-bit word index compared before any truncation to the array index width.
  assign w_in_range    = ({2'b00, w_cur_addr[31:2]} < 32'(DEPTH));
  assign w_idx         = w_cur_addr[AW+1:2];
  assign w_unused_addr = ^w_cur_addr[1:0];

  always_comb begin
    w_we_ok = 1'b0;
    case (w_cur_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: w_we_ok = 1'b1;
      default: w_we_ok = 1'b0;
    endcase
  end

  assign w_legal = w_in_range && w_we_ok;

  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_cur_we[i]) w_merged[8*i +: 8] = w_cur_wdata[8*i +: 8];
    end
  end

  // Array is never reset; gating on reset keeps a coincident reset from committing a write.
  always_ff @(posedge clk) begin
    if (reset && w_commit && w_legal && (w_cur_we != 4'b0000)) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_we_nxt    = r_we;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_addr_nxt  = req_addr;
          w_we_nxt    = req_we;
          w_wdata_nxt = req_wdata;
          if (NoWait) begin
            w_state_nxt = StResp;
          end else begin
            w_cnt_nxt   = WaitLoad;
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) w_state_nxt = StResp;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      StResp: begin
        if (rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_commit) begin
      w_rdata_nxt = w_legal ? w_merged : 32'd0;
      w_err_nxt   = !w_legal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_we    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = (r_state == StResp);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_CYCLES=2 main instance, plus 0 and 15 wait-state
// instances for back-to-back throughput and counter-width latency.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_we;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_we;
  logic        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready, c_rsp_err;
  logic [31:0] c_req_addr, c_req_wdata, c_rsp_rdata;
  logic [3:0]  c_req_we;

  int n_pass = 0;
  int n_total = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_addr(a_req_addr), .req_we(a_req_we), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .req_we(b_req_we), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(15)) u_dut_c (
    .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_addr(c_req_addr), .req_we(c_req_we), .req_wdata(c_req_wdata),
    .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_rdata(c_rsp_rdata),
    .rsp_err(c_rsp_err)
  );

  // One full transaction on instance A with rsp_ready high; lat counts the acceptance edge.
  task automatic a_xfer(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    a_req_addr = addr; a_req_we = we; a_req_wdata = wdata; a_req_valid = 1'b1;
    n = 0;
    while (!a_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = a_rsp_rdata; err = a_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_req_valid = 0; a_req_addr = 0; a_req_we = 0; a_req_wdata = 0; a_rsp_ready = 1'b1;
    b_req_valid = 0; b_req_addr = 0; b_req_we = 0; b_req_wdata = 0; b_rsp_ready = 1'b1;
    c_req_valid = 0; c_req_addr = 0; c_req_we = 0; c_req_wdata = 0; c_rsp_ready = 1'b1;
    #1;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", a_req_ready); else n_pass++;
    n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", a_rsp_valid); else n_pass++;
    n_total++; if (a_rsp_rdata !== 32'd0) $display("FAIL rst_rsp_rdata got=%h exp=0", a_rsp_rdata); else n_pass++;
    n_total++; if (a_rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b exp=0", a_rsp_err); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    a_xfer(32'h10, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    n_total++; if (lat !== 3) $display("FAIL wr_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL wr_rdata got=%h exp=deadbeef", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL wr_err got=%b exp=0", er); else n_pass++;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL wr_ready_back got=%b exp=1", a_req_ready); else n_pass++;
    a_xfer(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (lat !== 3) $display("FAIL rd_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_rdata got=%h exp=deadbeef", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL rd_err got=%b exp=0", er); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    a_xfer(32'h10, 4'b0010, 32'hAAAAAAAA, rd, er, lat);
    a_xfer(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hDEADAAEF) $display("FAIL byte_wr got=%h exp=deadaaef", rd); else n_pass++;
    a_xfer(32'h10, 4'b1100, 32'h12341234, rd, er, lat);
    n_total++; if (rd !== 32'h1234AAEF) $display("FAIL half_wr_rsp got=%h exp=1234aaef", rd); else n_pass++;
    a_xfer(32'h13, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h1234AAEF) $display("FAIL half_rd_lowbits got=%h exp=1234aaef", rd); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat;
    a_xfer(32'h10, 4'b0101, 32'hFFFFFFFF, rd, er, lat);
    n_total++; if (er !== 1'b1) $display("FAIL bad_we_err got=%b exp=1", er); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL bad_we_rdata got=%h exp=0", rd); else n_pass++;
    a_xfer(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h1234AAEF) $display("FAIL bad_we_no_write got=%h exp=1234aaef", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL read_err got=%b exp=0", er); else n_pass++;
    a_xfer(32'h1000, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (er !== 1'b1) $display("FAIL oor_err got=%b exp=1", er); else n_pass++;
    n_total++; if (rd !== 32'd0) $display("FAIL oor_rdata got=%h exp=0", rd); else n_pass++;
    a_xfer(32'h80000010, 4'b1111, 32'h0, rd, er, lat);
    n_total++; if (er !== 1'b1) $display("FAIL oor_high_err got=%b exp=1", er); else n_pass++;
    a_xfer(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h1234AAEF) $display("FAIL oor_alias got=%h exp=1234aaef", rd); else n_pass++;
    a_xfer(32'hFFC, 4'b1111, 32'h11223344, rd, er, lat);
    n_total++; if (er !== 1'b0) $display("FAIL last_word_err got=%b exp=0", er); else n_pass++;
    n_total++; if (rd !== 32'h11223344) $display("FAIL last_word_rdata got=%h exp=11223344", rd); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    a_rsp_ready = 1'b0;
    a_req_addr = 32'h10; a_req_we = 4'b0000; a_req_wdata = 32'h0; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat !== 3) $display("FAIL bp_latency got=%0d exp=3", lat); else n_pass++;
    // A write presented while busy must not be captured.
    a_req_addr = 32'h10; a_req_we = 4'b1111; a_req_wdata = 32'h0; a_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", i, a_rsp_valid); else n_pass++;
      n_total++; if (a_rsp_rdata !== 32'h1234AAEF) $display("FAIL bp_rdata[%0d] got=%h exp=1234aaef", i, a_rsp_rdata); else n_pass++;
      n_total++; if (a_rsp_err !== 1'b0) $display("FAIL bp_err[%0d] got=%b exp=0", i, a_rsp_err); else n_pass++;
      n_total++; if (a_req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, a_req_ready); else n_pass++;
      @(posedge clk); #1;
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", a_rsp_valid); else n_pass++;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", a_req_ready); else n_pass++;
    a_xfer(32'h10, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h1234AAEF) $display("FAIL bp_ignored_req got=%h exp=1234aaef", rd); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic er; int lat;
    a_xfer(32'h20, 4'b1111, 32'h000000AA, rd, er, lat);
    a_req_addr = 32'h20; a_req_we = 4'b1111; a_req_wdata = 32'h55; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_total++; if (a_req_ready !== 1'b1) $display("FAIL rstw_req_ready got=%b exp=1", a_req_ready); else n_pass++;
    n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL rstw_rsp_valid got=%b exp=0", a_rsp_valid); else n_pass++;
    n_total++; if (a_rsp_rdata !== 32'd0) $display("FAIL rstw_rsp_rdata got=%h exp=0", a_rsp_rdata); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    a_xfer(32'h20, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h000000AA) $display("FAIL rstw_discard got=%h exp=000000aa", rd); else n_pass++;
    // Reset while the response is held: response dropped, write kept.
    a_rsp_ready = 1'b0;
    a_req_addr = 32'h24; a_req_we = 4'b1111; a_req_wdata = 32'h77; a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    reset = 1'b0;
    #1;
    n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL rstr_rsp_valid got=%b exp=0", a_rsp_valid); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1; a_rsp_ready = 1'b1;
    a_xfer(32'h24, 4'b0000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h00000077) $display("FAIL rstr_kept got=%h exp=00000077", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    b_req_addr = 32'h8; b_req_we = 4'b1111; b_req_wdata = 32'hCAFEF00D; b_req_valid = 1'b1;
    @(posedge clk); #1;
    n_total++; if (b_rsp_valid !== 1'b1) $display("FAIL b2b_latency got=%b exp=1", b_rsp_valid); else n_pass++;
    n_total++; if (b_rsp_rdata !== 32'hCAFEF00D) $display("FAIL b2b_wr got=%h exp=cafef00d", b_rsp_rdata); else n_pass++;
    b_req_we = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (b_rsp_valid !== 1'(i % 2)) $display("FAIL b2b_valid[%0d] got=%b exp=%0d", i, b_rsp_valid, i % 2);
      else n_pass++;
      if (i % 2 == 1) begin
        n_total++; if (b_rsp_rdata !== 32'hCAFEF00D) $display("FAIL b2b_rd[%0d] got=%h exp=cafef00d", i, b_rsp_rdata); else n_pass++;
      end
    end
    b_req_addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    n_total++; if (b_rsp_err !== 1'b1) $display("FAIL b2b_oor_err got=%b exp=1", b_rsp_err); else n_pass++;
    n_total++; if (b_rsp_rdata !== 32'd0) $display("FAIL b2b_oor_rdata got=%h exp=0", b_rsp_rdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_max_wait();
    int lat;
    c_req_addr = 32'h4; c_req_we = 4'b1111; c_req_wdata = 32'h0BADF00D; c_req_valid = 1'b1;
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    lat = 1;
    while (!c_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat !== 16) $display("FAIL w15_latency got=%0d exp=16", lat); else n_pass++;
    n_total++; if (c_rsp_rdata !== 32'h0BADF00D) $display("FAIL w15_rdata got=%h exp=0badf00d", c_rsp_rdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    test_max_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
